// File: rtl/zanagotchi_pkg.sv
// Shared types and default timing constants for the zanagotchi input path.
//   estado_botao_t      : per-button debounce FSM state
//   DEB_CICLOS_PADRAO   : default debounce window (10 ms at 50 MHz)
//   LONGO_CICLOS_PADRAO : default long-press hold time (1 s at 50 MHz)
package zanagotchi_pkg;

  typedef enum logic [1:0] {
    SOLTO,
    PRESSIONADO,
    LONGO
  } estado_botao_t;

  localparam int unsigned DEB_CICLOS_PADRAO   = 500_000;
  localparam int unsigned LONGO_CICLOS_PADRAO = 50_000_000;

endpackage

// File: rtl/debounce_botao.sv
// Single-button conditioner: polarity normalisation, 2-FF synchroniser,
// debounce counter, hold counter and a three-state FSM.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   btn_raw      : asynchronous raw pad
//   nivel        : debounced pressed level as it becomes after the current
//                  edge (lets the parent build edge events aligned with pulso)
//   pulso        : registered one-cycle pulse on an accepted press
//   pulso_longo  : registered one-cycle pulse when the hold time is reached
module debounce_botao
  import zanagotchi_pkg::*;
#(
  parameter int unsigned DEB_CICLOS   = DEB_CICLOS_PADRAO,
  parameter int unsigned LONGO_CICLOS = LONGO_CICLOS_PADRAO,
  parameter logic        ATIVO_BAIXO  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic nivel,
  output logic pulso,
  output logic pulso_longo
);

  localparam int unsigned DW = $clog2(DEB_CICLOS + 1);
  localparam int unsigned HW = $clog2(LONGO_CICLOS + 1);
  localparam logic [DW-1:0] DEB_ULT   = DW'(DEB_CICLOS - 1);
  localparam logic [HW-1:0] LONGO_ULT = HW'(LONGO_CICLOS - 1);
  localparam logic [HW-1:0] LONGO_MAX = HW'(LONGO_CICLOS);

  logic          pressionado;
  logic          sinc1;
  logic          sinc2;
  estado_botao_t estado;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          nivel_q;
  logic          difere;
  logic          aceita;

  assign pressionado = btn_raw ^ ATIVO_BAIXO;

  // Synchroniser resets to the released (normalised 0) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sinc1 <= 1'b0;
      sinc2 <= 1'b0;
    end else begin
      sinc1 <= pressionado;
      sinc2 <= sinc1;
    end
  end

  // The debounced level is implied by the FSM state; aceita marks the
  // edge on which the DEB_CICLOS-th consecutive differing cycle is seen.
  always_comb begin
    nivel_q = (estado != SOLTO);
    difere  = sinc2 ^ nivel_q;
    aceita  = difere && (deb_cnt == DEB_ULT);
    nivel   = nivel_q ^ aceita;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= SOLTO;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      pulso       <= 1'b0;
      pulso_longo <= 1'b0;
    end else begin
      pulso       <= 1'b0;
      pulso_longo <= 1'b0;

      if (difere && !aceita)
        deb_cnt <= deb_cnt + 1'b1;
      else
        deb_cnt <= '0;

      case (estado)
        SOLTO: begin
          if (aceita) begin
            estado   <= PRESSIONADO;
            hold_cnt <= '0;
            pulso    <= 1'b1;
          end
        end
        PRESSIONADO: begin
          // Hold keeps counting while a release is still being debounced;
          // an accepted release takes priority over reaching the hold time.
          if (aceita) begin
            estado <= SOLTO;
          end else if (hold_cnt == LONGO_ULT) begin
            estado      <= LONGO;
            hold_cnt    <= LONGO_MAX;
            pulso_longo <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONGO: begin
          if (aceita)
            estado <= SOLTO;
        end
        default: estado <= SOLTO;
      endcase
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Input conditioner for the two player push-buttons.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   btn1_raw, btn2_raw  : asynchronous raw pads
//   b1, b2              : one-cycle pulse on accepted press
//   b1_longo, b2_longo  : one-cycle pulse on reaching a long press
//   b_ambos             : one-cycle pulse when both debounced levels first
//                         become pressed together
// All outputs are registered.
module condicionador_botoes
  import zanagotchi_pkg::*;
#(
  parameter int unsigned DEB_CICLOS   = DEB_CICLOS_PADRAO,
  parameter int unsigned LONGO_CICLOS = LONGO_CICLOS_PADRAO,
  parameter logic        ATIVO_BAIXO  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic b1,
  output logic b2,
  output logic b1_longo,
  output logic b2_longo,
  output logic b_ambos
);

  logic nivel1;
  logic nivel2;
  logic ambos_ant;

  debounce_botao #(
    .DEB_CICLOS  (DEB_CICLOS),
    .LONGO_CICLOS(LONGO_CICLOS),
    .ATIVO_BAIXO (ATIVO_BAIXO)
  ) u_botao1 (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn1_raw),
    .nivel      (nivel1),
    .pulso      (b1),
    .pulso_longo(b1_longo)
  );

  debounce_botao #(
    .DEB_CICLOS  (DEB_CICLOS),
    .LONGO_CICLOS(LONGO_CICLOS),
    .ATIVO_BAIXO (ATIVO_BAIXO)
  ) u_botao2 (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn2_raw),
    .nivel      (nivel2),
    .pulso      (b2),
    .pulso_longo(b2_longo)
  );

  // nivelN is the post-edge level, so ambos_ant holds the current combined
  // level and b_ambos lands in the same cycle as the second bN pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ambos_ant <= 1'b0;
      b_ambos   <= 1'b0;
    end else begin
      ambos_ant <= nivel1 & nivel2;
      b_ambos   <= nivel1 & nivel2 & ~ambos_ant;
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LONGO = 20;
  localparam int unsigned LAT   = DEB + 2;

  localparam logic [4:0] M_B1 = 5'b00001;
  localparam logic [4:0] M_B2 = 5'b00010;
  localparam logic [4:0] M_L1 = 5'b00100;
  localparam logic [4:0] M_L2 = 5'b01000;
  localparam logic [4:0] M_AM = 5'b10000;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  vec;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r1 = 1'b0, r2 = 1'b0;
  logic a1 = 1'b1, a2 = 1'b1;
  logic b1, b2, l1, l2, am;
  logic ab1, ab2, abl1, abl2, abam;
  logic [4:0] obs_a, obs_ab, obs, exp_v;
  logic usar_ab = 1'b0;

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  ev_t fila[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs_a  = {am, l2, l1, b2, b1};
  assign obs_ab = {abam, abl2, abl1, ab2, ab1};

  condicionador_botoes #(
    .DEB_CICLOS  (DEB),
    .LONGO_CICLOS(LONGO),
    .ATIVO_BAIXO (1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn1_raw(r1), .btn2_raw(r2),
    .b1(b1), .b2(b2), .b1_longo(l1), .b2_longo(l2), .b_ambos(am)
  );

  condicionador_botoes #(
    .DEB_CICLOS  (DEB),
    .LONGO_CICLOS(LONGO),
    .ATIVO_BAIXO (1'b1)
  ) dut_ab (
    .clk(clk), .rst(rst), .btn1_raw(a1), .btn2_raw(a2),
    .b1(ab1), .b2(ab2), .b1_longo(abl1), .b2_longo(abl2), .b_ambos(abam)
  );

  task automatic test_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 5'b0 || obs_ab !== 5'b0) begin
        failures++;
        $display("FAIL reset cyc=%0d obs=%b/%b exp=00000", cyc, obs_a, obs_ab);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== 5'b0 || obs_ab !== 5'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d obs=%b/%b exp=00000", cyc, obs_a, obs_ab);
      end
    end
  endtask

  task automatic test_clean_press();
    int unsigned n0;
    for (int t = 0; t < 24; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B1});
      end
      r1 = (t < 10);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL clean_press t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL clean_press_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_bounce();
    int unsigned n0;
    for (int t = 0; t < 36; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + 8 + LAT, M_B1});
      end
      // bounce on 0..7, settle at 8, 3-cycle release glitch at 17..19
      r1 = (t < 2) || (t >= 4 && t < 6) || (t >= 8 && t < 17) || (t >= 20 && t < 24);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL bounce t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL bounce_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_long_press();
    int unsigned n0;
    for (int t = 0; t < 64; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B1});
        fila.push_back('{n0 + LAT + LONGO, M_L1});
        fila.push_back('{n0 + 44 + LAT, M_B1});
      end
      r1 = (t < 30) || (t >= 44 && t < 54);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL long_press t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL long_press_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_combo();
    int unsigned n0;
    for (int t = 0; t < 56; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B1});
        fila.push_back('{n0 + 3 + LAT, M_B2 | M_AM});
        fila.push_back('{n0 + 30 + LAT, M_B1 | M_B2 | M_AM});
      end
      r1 = (t < 15) || (t >= 30 && t < 41);
      r2 = (t >= 3 && t < 15) || (t >= 30 && t < 41);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL combo t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL combo_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_reset_mid_hold();
    int unsigned n0;
    for (int t = 0; t < 56; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B2});
        fila.push_back('{n0 + 12 + LAT, M_B2});
        fila.push_back('{n0 + 12 + LAT + LONGO, M_L2});
      end
      r2  = (t < 42);
      rst = (t == 10) || (t == 11);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_hold t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_hold_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_limits();
    int unsigned n0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + 10 + LAT, M_B1});
      end
      // DEB-1 cycles high (rejected), then exactly DEB cycles high (accepted)
      r1 = (t < DEB - 1) || (t >= 10 && t < 10 + DEB);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL limits t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL limits_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B1});
        fila.push_back('{n0 + 2 * LAT + LAT, M_B1});
      end
      r1 = (t < LAT) || (t >= 2 * LAT && t < 3 * LAT);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_a;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL back_to_back t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_polarity();
    int unsigned n0;
    usar_ab = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        n0 = cyc;
        fila.push_back('{n0 + LAT, M_B1});
      end
      a1  = !(t < 10);
      a2  = 1'b1;
      rst = (t == 20) || (t == 21);
      @(negedge clk);
      exp_v = '0;
      for (int i = fila.size() - 1; i >= 0; i--)
        if (fila[i].cyc == cyc) begin exp_v |= fila[i].vec; fila.delete(i); end
      obs = obs_ab;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL polarity t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
    end
    checks++;
    if (fila.size() != 0) begin
      failures++;
      $display("FAIL polarity_missing pending=%0d exp=0", fila.size());
      fila.delete();
    end
    usar_ab = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_combo();
    test_reset_mid_hold();
    test_limits();
    test_back_to_back();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
